// File: rtl/q3_arb_ctrl_if.sv
// q3_arb_ctrl_if: requester/consumer bundle for the q3 arbiter.
//   req[2:0]       request, bit0=X bit1=Y bit2=Z
//   din_x/y/z      requester data (W bits)
//   ack[2:0]       one-hot capture strobe back to requesters
//   c1, c2         datapath selects (Y, Z)
//   f, f_valid     registered output toward the consumer
//   f_ready        consumer accept
//   busy           arbiter owns the output
// slave = arbiter side, master = requester/consumer side.
interface q3_arb_ctrl_if #(parameter int W = 8);
  logic [2:0]   req;
  logic [W-1:0] din_x, din_y, din_z;
  logic [2:0]   ack;
  logic         c1, c2;
  logic [W-1:0] f;
  logic         f_valid;
  logic         f_ready;
  logic         busy;

  modport slave  (input  req, din_x, din_y, din_z, f_ready,
                  output ack, c1, c2, f, f_valid, busy);
  modport master (output req, din_x, din_y, din_z, f_ready,
                  input  ack, c1, c2, f, f_valid, busy);
endinterface

// File: rtl/q3_arb_ctrl.sv
// q3_arb_ctrl: three-requester arbiter/sequencer for the shared
// priority-select output register f.
//   clock   rising-edge clock
//   resetn  asynchronous active-low reset
//   bus     q3_arb_ctrl_if.slave (req/din in, ack/c1/c2/f/f_valid/busy out,
//           f_ready in)
// One requester owns the output at a time for at most MAX_HOLD transfers.
// Priority: fixed Z > Y > X by default; round-robin starting after the
// last owner when Q3_ARB_RR_EN is defined.
module q3_arb_ctrl #(
  parameter int W        = 8,
  parameter int MAX_HOLD = 4
) (
  input logic          clock,
  input logic          resetn,
  q3_arb_ctrl_if.slave bus
);
  localparam int HCW = $clog2(MAX_HOLD + 1);
  localparam logic [1:0] RX = 2'd0, RY = 2'd1, RZ = 2'd2;

  typedef enum logic {IDLE, OWN} state_t;

  state_t         state;
  logic [1:0]     owner, last_owner, winner;
  logic [HCW-1:0] hold_cnt;
  logic [W-1:0]   f_q;
  logic           f_valid_q;
  logic           slot_free, own_req, xfer, last_beat;
  logic [W-1:0]   din_sel;

  assign slot_free = !f_valid_q || bus.f_ready;
  assign xfer      = (state == OWN) && own_req && slot_free;
  assign last_beat = (hold_cnt == HCW'(MAX_HOLD - 1));

  always_comb begin
    own_req = 1'b0;
    din_sel = bus.din_x;
    case (owner)
      RY:      begin own_req = bus.req[1]; din_sel = bus.din_y; end
      RZ:      begin own_req = bus.req[2]; din_sel = bus.din_z; end
      default: begin own_req = bus.req[0]; din_sel = bus.din_x; end
    endcase
  end

`ifdef Q3_ARB_RR_EN
  // Walk the three slots after last_owner from farthest to nearest so the
  // nearest requesting slot is the one left in winner.
  always_comb begin
    int         k;
    logic [1:0] k2;
    winner = RX;
    k      = 0;
    k2     = 2'd0;
    for (int i = 3; i >= 1; i--) begin
      k  = (int'(last_owner) + i) % 3;
      k2 = 2'(k);
      if (bus.req[k2]) winner = k2;
    end
  end
`else
  // Z over Y over X, same precedence as c2 over c1 in the datapath.
  always_comb begin
    if (bus.req[2])      winner = RZ;
    else if (bus.req[1]) winner = RY;
    else                 winner = RX;
  end
`endif

  always_comb begin
    bus.ack = 3'b000;
    if (xfer) bus.ack[owner] = 1'b1;
  end

  assign bus.c1      = (state == OWN) && (owner == RY);
  assign bus.c2      = (state == OWN) && (owner == RZ);
  assign bus.busy    = (state == OWN);
  assign bus.f       = f_q;
  assign bus.f_valid = f_valid_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      owner      <= RX;
      hold_cnt   <= '0;
      last_owner <= RY;
      f_q        <= '0;
      f_valid_q  <= 1'b0;
    end else begin
      // Output register: load on transfer, otherwise drain once consumed
      // (also in IDLE, so the last word of a burst is not left dangling).
      if (xfer) begin
        f_q       <= din_sel;
        f_valid_q <= 1'b1;
      end else if (f_valid_q && bus.f_ready) begin
        f_valid_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (|bus.req) begin
            state    <= OWN;
            owner    <= winner;
            hold_cnt <= '0;
          end
        end
        OWN: begin
          if (xfer) begin
            if (last_beat) begin
              state      <= IDLE;
              last_owner <= owner;
              hold_cnt   <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end else if (!own_req) begin
            // Stalled owners keep the grant; only a dropped request releases.
            state      <= IDLE;
            last_owner <= owner;
            hold_cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_q3_arb_ctrl.sv
module tb_q3_arb_ctrl;
  localparam int W  = 8;
  localparam int MH = 4;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  q3_arb_ctrl_if #(.W(W)) bus();
  q3_arb_ctrl #(.W(W), .MAX_HOLD(MH)) dut (.clock(clock), .resetn(resetn), .bus(bus.slave));

  typedef struct packed {
    logic [2:0]   ack;
    logic         c1, c2, busy;
    logic [W-1:0] f;
    logic         fv;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Transaction-level reference: who owns (-1 = nobody), words sent in this
  // grant, previous owner, and the expected output register.
  int           m_own  = -1;
  int           m_cnt  = 0;
  int           m_last = 1;
  logic         m_fv   = 1'b0;
  logic [W-1:0] m_f    = '0;
  logic [2:0]   m_ack  = '0;
  logic [2:0]   reqs   = '0;
  logic [W-1:0] din [3];
  int           nacks [3];

  function automatic int pick(input logic [2:0] r, input int last);
`ifdef Q3_ARB_RR_EN
    for (int i = 1; i <= 3; i++) if (r[(last + i) % 3]) return (last + i) % 3;
`else
    for (int i = 2; i >= 0; i--) if (r[i]) return i;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_own = -1; m_cnt = 0; m_last = 1; m_fv = 1'b0; m_f = '0; m_ack = '0; reqs = '0;
  endtask

  // One clock cycle: requesters present data (holding it until acked),
  // the reference predicts this cycle and the state after the edge.
  task automatic cycle(input logic [2:0] want, input logic fr);
    exp_t e;
    logic slot;
    @(negedge clock);
    for (int i = 0; i < 3; i++)
      if (!(reqs[i] && !m_ack[i])) begin
        reqs[i] = want[i];
        din[i]  = W'($urandom);
      end
    bus.req = reqs; bus.din_x = din[0]; bus.din_y = din[1]; bus.din_z = din[2];
    bus.f_ready = fr;
    #1;
    e      = '0;
    e.c1   = (m_own == 1);
    e.c2   = (m_own == 2);
    e.busy = (m_own >= 0);
    slot   = !m_fv || fr;
    if (m_own < 0) begin
      if (m_fv && fr) m_fv = 1'b0;
      if (reqs != 3'b000) begin m_own = pick(reqs, m_last); m_cnt = 0; end
    end else if (reqs[m_own] && slot) begin
      e.ack[m_own] = 1'b1;
      m_f = din[m_own]; m_fv = 1'b1; m_cnt++; nacks[m_own]++;
      if (m_cnt == MH) begin m_last = m_own; m_own = -1; end
    end else begin
      if (m_fv && fr) m_fv = 1'b0;
      if (!reqs[m_own]) begin m_last = m_own; m_own = -1; end
    end
    m_ack = e.ack;
    e.f = m_f; e.fv = m_fv;
    q.push_back(e);
  endtask

  task automatic chk_rst(input string nm);
    n_cmp++;
    if (bus.ack !== 3'b000 || bus.c1 !== 1'b0 || bus.c2 !== 1'b0 || bus.busy !== 1'b0 ||
        bus.f !== '0 || bus.f_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: ack=%b c1=%b c2=%b busy=%b f=%h f_valid=%b, required all zero",
               nm, bus.ack, bus.c1, bus.c2, bus.busy, bus.f, bus.f_valid);
    end
  endtask

  // Monitor: pops one expectation per driven cycle, checks the
  // combinational outputs before the edge and the register after it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #4;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if ({bus.ack, bus.c1, bus.c2, bus.busy} !== {e.ack, e.c1, e.c2, e.busy}) begin
          n_bad++;
          $display("FAIL sel @%0t: ack=%b c1=%b c2=%b busy=%b, expected ack=%b c1=%b c2=%b busy=%b",
                   $time, bus.ack, bus.c1, bus.c2, bus.busy, e.ack, e.c1, e.c2, e.busy);
        end
        n_cmp++;
        if (!$onehot0(bus.ack) || (bus.c1 && bus.c2) || ((bus.ack & ~bus.req) != 3'b000)) begin
          n_bad++;
          $display("FAIL invariant @%0t: ack=%b req=%b c1=%b c2=%b", $time, bus.ack, bus.req, bus.c1, bus.c2);
        end
        @(posedge clock);
        #1;
        n_cmp++;
        if (bus.f !== e.f || bus.f_valid !== e.fv) begin
          n_bad++;
          $display("FAIL fout @%0t: f=%h f_valid=%b, expected f=%h f_valid=%b",
                   $time, bus.f, bus.f_valid, e.f, e.fv);
        end
      end
    end
  end

  initial begin
    int g;
    bus.req = '0; bus.din_x = '0; bus.din_y = '0; bus.din_z = '0; bus.f_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin din[i] = '0; nacks[i] = 0; end
    #12;
    chk_rst("reset");
    @(negedge clock);
    resetn = 1'b1;

    // All three requesting, consumer always ready.
    repeat (24) cycle(3'b111, 1'b1);
    repeat (30) cycle(3'b000, 1'b1);

    // X sends two words then drops.
    nacks[0] = 0; g = 0;
    while (nacks[0] < 2 && g < 50) begin cycle(3'b001, 1'b1); g++; end
    repeat (4) cycle(3'b000, 1'b1);

    // Y alone with the consumer stalled after the first word.
    nacks[1] = 0; g = 0;
    while (nacks[1] < 1 && g < 50) begin cycle(3'b010, 1'b1); g++; end
    repeat (3) cycle(3'b010, 1'b0);
    repeat (8) cycle(3'b010, 1'b1);
    repeat (20) cycle(3'b000, 1'b1);

    // Reset in the middle of a Z burst.
    repeat (3) cycle(3'b100, 1'b1);
    @(negedge clock);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations pending, required 0", q.size());
      q.delete();
    end
    #2;
    resetn = 1'b0;
    #1;
    chk_rst("midreset");
    model_reset();
    bus.req = 3'b000;
    @(negedge clock);
    resetn = 1'b1;

    // Random traffic.
    repeat (10000) cycle(3'($urandom), ($urandom_range(0, 3) != 0));

    @(negedge clock);
    #7;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL final_drain: %0d expectations pending, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/q3_arb_ctrl.md
# q3_arb_ctrl

Three-requester arbiter and sequencer for the shared priority-select output register. Requesters X, Y and Z compete for one W-bit registered output `f`. The block grants ownership to one requester at a time and drives the `c1`/`c2` selects of the shared datapath. It also runs a valid/ready handshake toward the consumer and limits each grant to a bounded burst.

## Interface
- `W`, 8: data width of each requester and of `f`.
- `MAX_HOLD`, 4: maximum transfers per grant (≥1).

- `clock`  in  1  rising-edge clock.
- `resetn`  in  1  asynchronous active-low reset.
- `req`  in  3  request; bit0=X, bit1=Y, bit2=Z.
- `din_x`, `din_y`, `din_z`  in  W each  requester data.
- `ack`  out  3  one-hot; data of that requester is captured at this edge.
- `c1`  out  1  datapath select Y (combinational from state).
- `c2`  out  1  datapath select Z (combinational from state).
- `f`  out  W  registered output data.
- `f_valid`  out  1  `f` holds unconsumed data.
- `f_ready`  in  1  consumer accepts `f` when `f_valid` is high.
- `busy`  out  1  high in OWN.

## Operation
- FSM states:
  - IDLE: no owner.
  - OWN: `owner` ∈ {X,Y,Z}.
  - `hold_cnt` is a 0..MAX_HOLD counter.
- Slot free is defined as `!f_valid || f_ready`.
- IDLE:
  - If `req` ≠ 0, pick the winner by the priority rule and go to OWN with `owner` = winner and `hold_cnt` = 0.
  - No `ack` is issued in IDLE.
- OWN, transfer condition `req[owner] && slot free`:
  - `ack[owner]` = 1 combinationally.
  - `f` <= din of `owner`, `f_valid` <= 1, `hold_cnt` += 1.
- OWN, no transfer while slot free and `f_valid`: `f_valid` <= 0. Consumption is then complete.
- Leave OWN for IDLE at the edge where either:
  - `req[owner]` is low, or
  - a transfer occurs with `hold_cnt` == MAX_HOLD−1.
- On leaving OWN, `last_owner` <= `owner`.
- Selects:
  - `c2` = (OWN && owner==Z).
  - `c1` = (OWN && owner==Y).
  - Never both high. Both low in IDLE, where the datapath defaults to X.
- `ack` is one-hot or zero. It is never asserted for a requester whose `req` is low.
- Requesters update or drop data only after an edge with their `ack` high.
- A stalled consumer (`f_ready` low with `f_valid` high) blocks transfers. Ownership is kept, and `hold_cnt` does not advance.
- Reset values: state IDLE, `owner`=X, `hold_cnt`=0, `last_owner`=Y, `f`=0, `f_valid`=0, `ack`=0, `c1`=`c2`=0, `busy`=0.
- Reset mid-burst aborts immediately. Any partially issued burst is not resumed.

## Timing
- Request latency: `req` rises before edge n while IDLE.
  - The block enters OWN at edge n.
  - The first `ack` is in cycle n→n+1 if the slot is free.
  - `f`/`f_valid` are updated at edge n+1.
- Throughput while owning with `f_ready`=1: one transfer per cycle.
- Each grant costs one IDLE cycle of arbitration. Back-to-back bursts from different owners are separated by exactly one non-transfer cycle.
- If `f_valid`=1 and `f_ready`=1 with a transfer in the same cycle, the old data is consumed and the new data is loaded. `f_valid` stays 1.
- The release edge and the IDLE arbitration never coincide. A requester dropping `req` at the same edge its last `ack` fires is legal.

## Configuration
- `Q3_ARB_RR_EN` defined: round-robin priority.
  - The search order starts after `last_owner`: X→Y→Z→X.
  - The reset `last_owner`=Y gives first order Z, X, Y.
- `Q3_ARB_RR_EN` undefined: fixed priority Z > Y > X, matching the datapath's `c2`-over-`c1` precedence.
  - `last_owner` is still maintained but does not affect the decision.

## Test plan
- Reset, then `req`=3'b111 with `f_ready`=1 under the fixed-priority build: Z owns, `c2`=1. Four acks and `f` shows `din_z` values over 4 cycles; release, IDLE for 1 cycle, then Z again.
- Same stimulus under the `Q3_ARB_RR_EN` build: grant order Z, X, Y, Z. Each burst is exactly 4 transfers. `c1`/`c2` match the owner.
- Y alone, `f_ready` held low after the first transfer for 3 cycles: `ack` stays low, `f` is stable, `hold_cnt` is frozen. Release `f_ready`: transfers resume, and the burst completes at 4 total.
- X requests 2 words then drops `req`: 2 acks, OWN→IDLE at the drop, `f_valid` falls after consumption, `busy`=0.
- Assert `resetn` low during a Z burst: `f`=0, `f_valid`=0, `ack`=0 and `c1`=`c2`=0 immediately. After release, arbitration restarts from IDLE.
- Random `req`/`f_ready` for 10k cycles: `ack` one-hot or zero, never both `c1` and `c2` high, and `f` always equals the din of the acked requester at the previous edge.
